wb_merge_unit: RTL and testbench

WB_MERGE_UNIT -- requirements
Module: wb_merge_unit

---
 rtl/wb_merge_unit.sv | 169 ++++++++++++++++
 tb/tb_wb_merge_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_merge_unit.sv
// Write-back merge unit: buffers register-file writes from several producer
// channels in per-channel FIFOs and drains them one per cycle round-robin
// onto a single registered register-file write port.
module wb_merge_unit #(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic [NUM_CH-1:0]     ch_valid_i,
    output logic [NUM_CH-1:0]     ch_ready_o,
    input  logic [NUM_CH-1:0]     ch_reg_write_i,
    input  logic [5*NUM_CH-1:0]   ch_rd_addr_i,
    input  logic [2*NUM_CH-1:0]   ch_mem_to_reg_i,
    input  logic [32*NUM_CH-1:0]  ch_ex_result_i,
    input  logic [32*NUM_CH-1:0]  ch_mem_read_data_i,
    input  logic [32*NUM_CH-1:0]  ch_pc_plus_4_i,
    input  logic [3*NUM_CH-1:0]   ch_load_funct3_i,
    input  logic [2*NUM_CH-1:0]   ch_byte_off_i,
    output logic                  reg_write_o,
    output logic [4:0]            rd_addr_o,
    output logic [31:0]           write_data_o,
    output logic                  busy_o
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    // Write-back source select codes (shared with the core's defines).
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [GW-1:0] LAST_CH  = GW'(NUM_CH - 1);

    // Entry layout: {rd[4:0], data[31:0]}
    logic [36:0]       fifo_mem [NUM_CH][FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q [NUM_CH];
    logic [AW-1:0]     rd_ptr_q [NUM_CH];
    logic [CW-1:0]     count_q  [NUM_CH];
    logic [GW-1:0]     last_grant_q;

    logic [31:0]       wb_data [NUM_CH];
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic              grant_valid;
    logic [GW-1:0]     grant_idx;
    logic [36:0]       head;

    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  load_ext = {{24{b[7]}}, b};
            3'b100:  load_ext = {24'd0, b};
            3'b001:  load_ext = {{16{h[15]}}, h};
            3'b101:  load_ext = {16'd0, h};
            default: load_ext = w;
        endcase
    endfunction

    // Ready and busy come only from registered counts.
    always_comb begin
        busy_o = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            ch_ready_o[k] = (count_q[k] != FULL_CNT);
            if (count_q[k] != '0) busy_o = 1'b1;
        end
    end

    // Round-robin pick starting just after the last granted channel.
    always_comb begin
        logic [GW-1:0] cand;
        int            c;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            c = int'(last_grant_q) + 1 + i;
            if (c >= int'(NUM_CH)) c = c - int'(NUM_CH);
            cand = GW'(c);
            if (!grant_valid && (count_q[cand] != '0)) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Per-channel write data select and push/pop qualification.
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            case (ch_mem_to_reg_i[2*k +: 2])
                WB_MEM:  wb_data[k] = load_ext(ch_mem_read_data_i[32*k +: 32],
                                               ch_load_funct3_i[3*k +: 3],
                                               ch_byte_off_i[2*k +: 2]);
                WB_PC4:  wb_data[k] = ch_pc_plus_4_i[32*k +: 32];
                WB_ALU:  wb_data[k] = ch_ex_result_i[32*k +: 32];
                default: wb_data[k] = ch_ex_result_i[32*k +: 32];
            endcase
            // Writes to x0 or with reg_write low are accepted but dropped.
            push[k] = ch_valid_i[k] & ch_ready_o[k] & ch_reg_write_i[k] &
                      (ch_rd_addr_i[5*k +: 5] != 5'd0) & ~flush_i;
            pop[k]  = grant_valid & (grant_idx == GW'(k)) & ~flush_i;
        end
    end

    // Head entry of the granted FIFO.
    always_comb begin
        head = fifo_mem[grant_idx][rd_ptr_q[grant_idx]];
    end

    // FIFO pointers and occupancy; flush and reset empty everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
                count_q[k]  <= '0;
            end
        end else if (flush_i) begin
            for (int k = 0; k < NUM_CH; k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
                count_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (push[k]) wr_ptr_q[k] <= wr_ptr_q[k] + AW'(1);
                if (pop[k])  rd_ptr_q[k] <= rd_ptr_q[k] + AW'(1);
                count_q[k] <= count_q[k] + CW'(push[k]) - CW'(pop[k]);
            end
        end
    end

    // FIFO storage; contents are don't-care while the count says empty.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_CH; k++) begin
            if (push[k]) fifo_mem[k][wr_ptr_q[k]] <= {ch_rd_addr_i[5*k +: 5], wb_data[k]};
        end
    end

    // Registered write port and arbiter history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_write_o  <= 1'b0;
            rd_addr_o    <= 5'd0;
            write_data_o <= 32'd0;
            last_grant_q <= LAST_CH;
        end else if (!flush_i && grant_valid) begin
            reg_write_o  <= 1'b1;
            rd_addr_o    <= head[36:32];
            write_data_o <= head[31:0];
            last_grant_q <= grant_idx;
        end else begin
            reg_write_o  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_merge_unit.sv
// Directed self-checking bench for wb_merge_unit (NUM_CH=2, FIFO_DEPTH=4).
module tb_wb_merge_unit;

    localparam logic [1:0] ALU = 2'b00;
    localparam logic [1:0] MEM = 2'b01;
    localparam logic [1:0] PC4 = 2'b10;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic [1:0]  ch_valid_i;
    logic [1:0]  ch_ready_o;
    logic [1:0]  ch_reg_write_i;
    logic [9:0]  ch_rd_addr_i;
    logic [3:0]  ch_mem_to_reg_i;
    logic [63:0] ch_ex_result_i;
    logic [63:0] ch_mem_read_data_i;
    logic [63:0] ch_pc_plus_4_i;
    logic [5:0]  ch_load_funct3_i;
    logic [3:0]  ch_byte_off_i;
    logic        reg_write_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] write_data_o;
    logic        busy_o;

    int n_total = 0;
    int n_bad   = 0;

    wb_merge_unit #(.NUM_CH(2), .FIFO_DEPTH(4)) dut (
        .clk                (clk),
        .rst                (rst),
        .flush_i            (flush_i),
        .ch_valid_i         (ch_valid_i),
        .ch_ready_o         (ch_ready_o),
        .ch_reg_write_i     (ch_reg_write_i),
        .ch_rd_addr_i       (ch_rd_addr_i),
        .ch_mem_to_reg_i    (ch_mem_to_reg_i),
        .ch_ex_result_i     (ch_ex_result_i),
        .ch_mem_read_data_i (ch_mem_read_data_i),
        .ch_pc_plus_4_i     (ch_pc_plus_4_i),
        .ch_load_funct3_i   (ch_load_funct3_i),
        .ch_byte_off_i      (ch_byte_off_i),
        .reg_write_o        (reg_write_o),
        .rd_addr_o          (rd_addr_o),
        .write_data_o       (write_data_o),
        .busy_o             (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        ch_valid_i         = '0;
        ch_reg_write_i     = '0;
        ch_rd_addr_i       = '0;
        ch_mem_to_reg_i    = '0;
        ch_ex_result_i     = '0;
        ch_mem_read_data_i = '0;
        ch_pc_plus_4_i     = '0;
        ch_load_funct3_i   = '0;
        ch_byte_off_i      = '0;
    endtask

    task automatic drive(input int ch, input logic rw, input logic [4:0] rd,
                         input logic [1:0] sel, input logic [31:0] ex, input logic [31:0] mem,
                         input logic [31:0] pc, input logic [2:0] f3, input logic [1:0] off);
        ch_valid_i[ch]               = 1'b1;
        ch_reg_write_i[ch]           = rw;
        ch_rd_addr_i[5*ch +: 5]      = rd;
        ch_mem_to_reg_i[2*ch +: 2]   = sel;
        ch_ex_result_i[32*ch +: 32]  = ex;
        ch_mem_read_data_i[32*ch +: 32] = mem;
        ch_pc_plus_4_i[32*ch +: 32]  = pc;
        ch_load_funct3_i[3*ch +: 3]  = f3;
        ch_byte_off_i[2*ch +: 2]     = off;
    endtask

    // One isolated transfer on ch0 and its write-port result one edge later.
    task automatic send_one(input string tag, input logic [4:0] rd, input logic [1:0] sel,
                            input logic [31:0] mem, input logic [2:0] f3,
                            input logic [1:0] off, input logic [31:0] exp);
        drive(0, 1'b1, rd, sel, 32'hDEAD_BEEF, mem, 32'h0000_1004, f3, off);
        step();
        idle_all();
        step();
        check({tag, "_rw"}, reg_write_o, 1);
        check({tag, "_rd"}, rd_addr_o, rd);
        check({tag, "_data"}, write_data_o, exp);
    endtask

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    int          idx[2];
    logic        acc_pend[2];
    int          n_acc;
    int          n_out;
    logic        prev_ch;
    logic        cur_ch;
    logic        saw_full;
    logic [31:0] exp_d;

    initial begin
        rst     = 1'b1;
        flush_i = 1'b0;
        idle_all();
        repeat (2) @(posedge clk);
        #1;
        check("rst_rw", reg_write_o, 0);
        check("rst_rd", rd_addr_o, 0);
        check("rst_data", write_data_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_ready", ch_ready_o, 2'b11);
        rst = 1'b0;
        step();

        // Single ALU write: accepted at edge 1, visible after edge 2, then cleared.
        drive(0, 1'b1, 5'd5, ALU, 32'h1234_5678, 32'h0, 32'h0, 3'b010, 2'd0);
        step();
        check("alu_busy", busy_o, 1);
        check("alu_rw_early", reg_write_o, 0);
        idle_all();
        step();
        check("alu_rw", reg_write_o, 1);
        check("alu_rd", rd_addr_o, 5);
        check("alu_data", write_data_o, 32'h1234_5678);
        check("alu_busy_after", busy_o, 0);
        step();
        check("alu_rw_off", reg_write_o, 0);
        check("alu_data_hold", write_data_o, 32'h1234_5678);

        // Load extension and source select.
        send_one("lb3",  5'd6,  MEM, 32'h80FF_0000, 3'b000, 2'd3, 32'hFFFF_FF80);
        send_one("lhu2", 5'd7,  MEM, 32'h80FF_0000, 3'b101, 2'd2, 32'h0000_80FF);
        send_one("lh0",  5'd8,  MEM, 32'h80FF_0000, 3'b001, 2'd0, 32'h0000_0000);
        send_one("lbu3", 5'd9,  MEM, 32'h80FF_0000, 3'b100, 2'd3, 32'h0000_0080);
        send_one("lb2",  5'd10, MEM, 32'h80FF_0000, 3'b000, 2'd2, 32'hFFFF_FFFF);
        send_one("lw",   5'd11, MEM, 32'h80FF_0000, 3'b010, 2'd1, 32'h80FF_0000);
        send_one("pc4",  5'd12, PC4, 32'h80FF_0000, 3'b000, 2'd0, 32'h0000_1004);
        send_one("sel3", 5'd13, 2'b11, 32'h80FF_0000, 3'b000, 2'd0, 32'hDEAD_BEEF);

        // Discarded transfers: rd=0, then reg_write=0.
        drive(1, 1'b1, 5'd0, ALU, 32'h1111_1111, 32'h0, 32'h0, 3'b0, 2'd0);
        step();
        check("x0_busy", busy_o, 0);
        drive(1, 1'b0, 5'd7, ALU, 32'h2222_2222, 32'h0, 32'h0, 3'b0, 2'd0);
        step();
        check("x0_rw", reg_write_o, 0);
        check("norw_busy", busy_o, 0);
        idle_all();
        step();
        check("norw_rw", reg_write_o, 0);

        // Both channels valid for 8 cycles; last grant was ch0, so ch1 goes first.
        n_acc = 0; n_out = 0; prev_ch = 1'b0; saw_full = 1'b0;
        idx[0] = 0; idx[1] = 0; acc_pend[0] = 1'b0; acc_pend[1] = 1'b0;
        for (int cyc = 0; cyc < 24; cyc++) begin
            if (reg_write_o) begin
                cur_ch = rd_addr_o[4];
                check("rr_alt", cur_ch, !prev_ch);
                if (cur_ch == 1'b0) begin
                    if (q0.size() == 0) check("ord0_extra", write_data_o, 0);
                    else begin exp_d = q0.pop_front(); check("ord0", write_data_o, exp_d); end
                end else begin
                    if (q1.size() == 0) check("ord1_extra", write_data_o, 0);
                    else begin exp_d = q1.pop_front(); check("ord1", write_data_o, exp_d); end
                end
                prev_ch = cur_ch;
                n_out++;
            end
            for (int k = 0; k < 2; k++) begin
                if (acc_pend[k]) begin
                    exp_d = {(k == 1) ? 8'hB0 : 8'hA0, 16'h0, 8'(idx[k])};
                    if (k == 0) q0.push_back(exp_d);
                    else q1.push_back(exp_d);
                    idx[k]++;
                    n_acc++;
                end
            end
            if (!ch_ready_o[0]) saw_full = 1'b1;
            idle_all();
            for (int k = 0; k < 2; k++) begin
                if (cyc < 8) begin
                    drive(k, 1'b1, (k == 1) ? 5'(16 + idx[k]) : 5'(1 + idx[k]), ALU,
                          {(k == 1) ? 8'hB0 : 8'hA0, 16'h0, 8'(idx[k])},
                          32'h0, 32'h0, 3'b0, 2'd0);
                    acc_pend[k] = ch_ready_o[k];
                end else begin
                    acc_pend[k] = 1'b0;
                end
            end
            step();
        end
        check("rr_acc", n_acc, 14);
        check("rr_out", n_out, 14);
        check("rr_full_seen", saw_full, 1);
        check("rr_busy", busy_o, 0);

        // Flush with three entries buffered, a transfer offered on the flush edge.
        drive(0, 1'b1, 5'd3, ALU, 32'hF0F0_0001, 32'h0, 32'h0, 3'b0, 2'd0);
        drive(1, 1'b1, 5'd20, ALU, 32'hF0F0_0002, 32'h0, 32'h0, 3'b0, 2'd0);
        step();
        step();
        check("fl_busy_pre", busy_o, 1);
        idle_all();
        drive(1, 1'b1, 5'd21, ALU, 32'hF0F0_0003, 32'h0, 32'h0, 3'b0, 2'd0);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        idle_all();
        check("fl_busy", busy_o, 0);
        check("fl_rw", reg_write_o, 0);
        check("fl_ready", ch_ready_o, 2'b11);
        for (int i = 0; i < 3; i++) begin
            step();
            check("fl_stale", reg_write_o, 0);
        end

        // Asynchronous reset between edges with two entries buffered.
        drive(0, 1'b1, 5'd4, ALU, 32'hC0C0_0001, 32'h0, 32'h0, 3'b0, 2'd0);
        drive(1, 1'b1, 5'd22, ALU, 32'hC0C0_0002, 32'h0, 32'h0, 3'b0, 2'd0);
        step();
        idle_all();
        drive(0, 1'b1, 5'd5, ALU, 32'hC0C0_0003, 32'h0, 32'h0, 3'b0, 2'd0);
        step();
        idle_all();
        check("ar_rw_pre", reg_write_o, 1);
        check("ar_busy_pre", busy_o, 1);
        #2 rst = 1'b1;
        #1;
        check("ar_busy", busy_o, 0);
        check("ar_rw", reg_write_o, 0);
        check("ar_data", write_data_o, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("ar_stale", reg_write_o, 0);
            check("ar_busy_post", busy_o, 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
